// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: runs a programmed shift amount STEP bits per
// clock, with start/busy/done handshake and serial fill/drain.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for start; modes 0/1 and zero-amount shifts finish here
// RUN   | applying up to STEP single-bit steps per edge until rem hits 0
module seq_shifter #(
  parameter int N    = 8,
  parameter int STEP = 1,
  parameter int SW   = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [SW-1:0] amt,
  input  logic [N-1:0]  in,
  input  logic          ser_in,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  out,
  output logic          ser_out
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  state_t        state;
  logic [2:0]    op;
  logic [SW-1:0] rem;
  logic [SW-1:0] k;
  logic [N-1:0]  nxt_out;
  logic          nxt_ser;

  assign k = (rem > STEP_W) ? STEP_W : rem;

  // k chained single-bit steps; ser_in is held constant across all of them
  always_comb begin
    nxt_out = out;
    nxt_ser = ser_out;
    for (int i = 0; i < STEP; i++) begin
      if (SW'(i) < k) begin
        case (op)
          3'd2: begin nxt_ser = nxt_out[0];   nxt_out = {1'b0, nxt_out[N-1:1]}; end
          3'd3: begin nxt_ser = nxt_out[N-1]; nxt_out = {nxt_out[N-2:0], 1'b0}; end
          3'd4: begin nxt_ser = nxt_out[0];   nxt_out = {nxt_out[N-1], nxt_out[N-1:1]}; end
          3'd5: begin nxt_ser = nxt_out[0];   nxt_out = {ser_in, nxt_out[N-1:1]}; end
          3'd6: begin nxt_ser = nxt_out[0];   nxt_out = {nxt_out[0], nxt_out[N-1:1]}; end
          3'd7: begin nxt_ser = nxt_out[N-1]; nxt_out = {nxt_out[N-2:0], nxt_out[N-1]}; end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= 3'd0;
      rem     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      out     <= '0;
      ser_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (mode)
              3'd0: begin out <= '0; done <= 1'b1; end
              3'd1: begin out <= in; done <= 1'b1; end
              default: begin
                if (amt == '0) begin
                  done <= 1'b1;
                end else begin
                  op    <= mode;
                  rem   <= amt;
                  busy  <= 1'b1;
                  state <= RUN;
                end
              end
            endcase
          end
        end
        RUN: begin
          out     <= nxt_out;
          ser_out <= nxt_ser;
          rem     <= rem - k;
          if (rem <= STEP_W) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: three instances (STEP=1,2,3) checked against
// a behavioural model through an expectation queue.
`timescale 1ns/1ps

module tb_seq_shifter;

  typedef struct {
    string      tag;
    logic [7:0] out;
    logic       ser;
    int         cycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  logic [2:0] mode;
  logic [3:0] amt;
  logic [7:0] in_d;
  logic       ser_in;
  logic [2:0] busy_v, done_v, ser_v;
  logic [7:0] out_v [3];

  int vectors = 0;
  int errs    = 0;
  int step_of [3] = '{1, 2, 3};
  logic [7:0] m_out [3];
  logic [2:0] m_ser;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_shifter #(.N(8), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode), .amt(amt), .in(in_d),
    .ser_in(ser_in), .busy(busy_v[0]), .done(done_v[0]), .out(out_v[0]), .ser_out(ser_v[0]));
  seq_shifter #(.N(8), .STEP(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode), .amt(amt), .in(in_d),
    .ser_in(ser_in), .busy(busy_v[1]), .done(done_v[1]), .out(out_v[1]), .ser_out(ser_v[1]));
  seq_shifter #(.N(8), .STEP(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode), .amt(amt), .in(in_d),
    .ser_in(ser_in), .busy(busy_v[2]), .done(done_v[2]), .out(out_v[2]), .ser_out(ser_v[2]));

  // returns {ser_out, out} after one single-bit step
  function automatic logic [8:0] mstep(input logic [7:0] d, input logic [2:0] m, input logic s);
    case (m)
      3'd2:    return {d[0], 1'b0, d[7:1]};
      3'd3:    return {d[7], d[6:0], 1'b0};
      3'd4:    return {d[0], d[7], d[7:1]};
      3'd5:    return {d[0], s, d[7:1]};
      3'd6:    return {d[0], d[0], d[7:1]};
      3'd7:    return {d[7], d[6:0], d[7]};
      default: return {1'b0, d};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Caller must be at a negedge; returns at the negedge where done was seen.
  task automatic run_op(input int d, input logic [2:0] m, input logic [3:0] a,
                        input logic [7:0] din, input logic [15:0] pat,
                        input string tag, input bit poke);
    exp_t e, got;
    int rem, k, ed, cyc, lat;
    logic [8:0] r;
    bit seen;
    ed = 0;
    if (m == 3'd0) m_out[d] = 8'h00;
    else if (m == 3'd1) m_out[d] = din;
    else begin
      rem = int'(a);
      while (rem > 0) begin
        k = (rem < step_of[d]) ? rem : step_of[d];
        for (int j = 0; j < k; j++) begin
          r = mstep(m_out[d], m, pat[ed]);
          m_out[d] = r[7:0];
          m_ser[d] = r[8];
        end
        rem -= k;
        ed++;
      end
    end
    e.tag = tag; e.out = m_out[d]; e.ser = m_ser[d]; e.cycles = ed;
    sb.push_back(e);

    start_v[d] = 1'b1; mode = m; amt = a; in_d = din;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    mode = 3'($urandom); amt = 4'($urandom); in_d = 8'($urandom);
    cyc = 0; lat = 0; seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      lat++;
      if (start_v[d]) start_v[d] = 1'b0;
      if (done_v[d]) seen = 1'b1;
      else if (busy_v[d]) begin
        ser_in = pat[cyc & 15];
        cyc++;
        if (poke && cyc == 2) begin start_v[d] = 1'b1; mode = 3'd0; end
      end
    end
    got = sb.pop_front();
    chk({got.tag, "_done"},   32'(seen), 32'd1);
    chk({got.tag, "_busycyc"}, cyc, got.cycles);
    chk({got.tag, "_latency"}, lat, got.cycles + 1);
    chk({got.tag, "_out"},    32'(out_v[d]), 32'(got.out));
    chk({got.tag, "_ser"},    32'(ser_v[d]), 32'(got.ser));
    chk({got.tag, "_busy0"},  32'(busy_v[d]), 32'd0);
  endtask

  initial begin
    int dn;
    rst = 1'b1; start_v = 3'b000; mode = 3'd0; amt = 4'd0; in_d = 8'h00; ser_in = 1'b0;
    for (int i = 0; i < 3; i++) m_out[i] = 8'h00;
    m_ser = 3'b000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_out",  32'(out_v[i]), 32'd0);
      chk("rst_busy", 32'(busy_v[i]), 32'd0);
      chk("rst_done", 32'(done_v[i]), 32'd0);
      chk("rst_ser",  32'(ser_v[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // load, then reset in the middle of a shift
    run_op(0, 3'd1, 4'd0, 8'hA5, 16'h0, "t1_load", 1'b0);
    chk("t1_load_const", 32'(out_v[0]), 32'hA5);
    start_v[0] = 1'b1; mode = 3'd2; amt = 4'd5;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t1_busy_mid", 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_abort_out",  32'(out_v[0]), 32'd0);
    chk("t1_abort_busy", 32'(busy_v[0]), 32'd0);
    chk("t1_abort_done", 32'(done_v[0]), 32'd0);
    rst = 1'b0;
    dn = 0;
    repeat (6) begin @(negedge clk); if (done_v[0]) dn++; end
    chk("t1_no_done_after_abort", dn, 0);
    for (int i = 0; i < 3; i++) m_out[i] = 8'h00;
    m_ser = 3'b000;

    // arithmetic right
    run_op(0, 3'd1, 4'd0, 8'h96, 16'h0, "t2_load", 1'b0);
    run_op(0, 3'd4, 4'd3, 8'h00, 16'h0, "t2_asr3", 1'b0);
    chk("t2_asr3_const", 32'(out_v[0]), 32'hF2);

    // rotate left with STEP=3, then zero-amount rotate
    run_op(2, 3'd1, 4'd0, 8'h81, 16'h0, "t3_load", 1'b0);
    run_op(2, 3'd7, 4'd7, 8'h00, 16'h0, "t3_rol7", 1'b0);
    chk("t3_rol7_const", 32'(out_v[2]), 32'hC0);
    run_op(2, 3'd6, 4'd0, 8'h00, 16'h0, "t3_ror0", 1'b0);

    // serial fill, ser_in = 1,0,1,1
    run_op(0, 3'd1, 4'd0, 8'h00, 16'h0, "t4_load", 1'b0);
    run_op(0, 3'd5, 4'd4, 8'h00, 16'h000D, "t4_ser4", 1'b0);
    chk("t4_ser4_const", 32'(out_v[0]), 32'hD0);

    // logical left by N with STEP=2, start pulsed while busy
    run_op(1, 3'd1, 4'd0, 8'hFF, 16'h0, "t5_load", 1'b0);
    run_op(1, 3'd3, 4'd8, 8'h00, 16'h0, "t5_lsl8", 1'b1);
    chk("t5_lsl8_const", 32'(out_v[1]), 32'h00);
    @(negedge clk);
    chk("t5_single_done", 32'(done_v[1]), 32'd0);

    // back-to-back on the done cycle
    run_op(0, 3'd1, 4'd0, 8'hE7, 16'h0, "t6_load", 1'b0);
    run_op(0, 3'd2, 4'd2, 8'h00, 16'h0, "t6_lsr2", 1'b0);
    run_op(0, 3'd1, 4'd0, 8'h3C, 16'h0, "t6_b2b", 1'b0);
    chk("t6_b2b_const", 32'(out_v[0]), 32'h3C);

    // amounts beyond N
    run_op(0, 3'd1, 4'd0, 8'h80, 16'h0, "t7_load", 1'b0);
    run_op(0, 3'd4, 4'd12, 8'h00, 16'h0, "t7_asr12", 1'b0);
    run_op(1, 3'd1, 4'd0, 8'h81, 16'h0, "t7_load1", 1'b0);
    run_op(1, 3'd6, 4'd10, 8'h00, 16'h0, "t7_ror10", 1'b0);
    run_op(2, 3'd1, 4'd0, 8'hFF, 16'h0, "t7_load2", 1'b0);
    run_op(2, 3'd2, 4'd9, 8'h00, 16'h0, "t7_lsr9", 1'b0);
    run_op(2, 3'd0, 4'd0, 8'h00, 16'h0, "t7_clear", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
